// File: rtl/cmp_serial_ctrl_if.sv
// Request/result bundle between a requester and cmp_serial_ctrl.
// master = requester side, slave = comparator controller side.
interface cmp_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lesser;
    logic             greater;
    logic             equal;

    modport master (
        output start, a, b,
        input  busy, done, lesser, greater, equal
    );

    modport slave (
        input  start, a, b,
        output busy, done, lesser, greater, equal
    );
endinterface

// File: rtl/cmp_serial_ctrl.sv
// Nibble-serial WIDTH-bit unsigned magnitude comparator controller (MSB nibble first).
// Optional macro CMP_SERIAL_EARLY_EXIT_EN: finish on the first unequal nibble.
//
// state | meaning
// IDLE  | waiting for start; busy=0, results hold last completion
// RUN   | scanning nibbles idx = NIB-1 .. 0; busy=1
module cmp_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    cmp_serial_ctrl_if.slave    bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

`ifdef CMP_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             dec_l_q,   dec_l_d;
    logic             dec_g_q,   dec_g_d;
    logic             done_q,    done_d;
    logic             lesser_q,  lesser_d;
    logic             greater_q, greater_d;
    logic             equal_q,   equal_d;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic       slice_l;
    logic       slice_g;
    logic       new_dec;
    logic       last_nib;
    logic       finish;

    // Shared 4-bit slice fed by the nibble selected by idx.
    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        slice_l = (nib_a < nib_b);
        slice_g = (nib_a > nib_b);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        dec_l_d   = dec_l_q;
        dec_g_d   = dec_g_q;
        done_d    = 1'b0;
        lesser_d  = lesser_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        new_dec   = 1'b0;
        last_nib  = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDX_TOP;
                    dec_l_d = 1'b0;
                    dec_g_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The most significant unequal nibble wins; later nibbles cannot override it.
                new_dec  = !dec_l_q && !dec_g_q && (slice_l || slice_g);
                dec_l_d  = dec_l_q || (new_dec && slice_l);
                dec_g_d  = dec_g_q || (new_dec && slice_g);
                last_nib = (idx_q == '0);
                finish   = last_nib || (EARLY_EXIT && new_dec);
                if (finish) begin
                    lesser_d  = dec_l_d;
                    greater_d = dec_g_d;
                    equal_d   = !(dec_l_d || dec_g_d);
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dec_l_q   <= 1'b0;
            dec_g_q   <= 1'b0;
            done_q    <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dec_l_q   <= dec_l_d;
            dec_g_q   <= dec_g_d;
            done_q    <= done_d;
            lesser_q  <= lesser_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.lesser  = lesser_q;
    assign bus.greater = greater_q;
    assign bus.equal   = equal_q;
endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// Scoreboard bench for cmp_serial_ctrl at WIDTH=16; follows CMP_SERIAL_EARLY_EXIT_EN for latency.
module tb_cmp_serial_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    typedef struct {
        logic l;
        logic g;
        logic e;
        int   lat;
        int   e0;
    } exp_t;

    exp_t sb[$];

    cmp_serial_ctrl_if #(.WIDTH(16)) bus ();

    cmp_serial_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y);
`ifdef CMP_SERIAL_EARLY_EXIT_EN
        for (int p = 0; p < 4; p++)
            if (x[15-4*p -: 4] != y[15-4*p -: 4]) return p + 1;
`endif
        return 4;
    endfunction

    // Called at a falling edge; the next rising edge is E0.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        e.l   = (x < y);
        e.g   = (x > y);
        e.e   = (x == y);
        e.lat = exp_lat(x, y);
        e.e0  = cyc + 1;
        sb.push_back(e);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(bus.done), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_cnt++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("lesser",  32'(bus.lesser),  32'(e.l));
                chk("greater", 32'(bus.greater), 32'(e.g));
                chk("equal",   32'(bus.equal),   32'(e.e));
                chk("latency", 32'(cyc - e.e0),  32'(e.lat));
                chk("busy_at_done", 32'(bus.busy), 0);
            end
        end
    end

    initial begin
        int cnt0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_done",    32'(bus.done),    0);
        chk("rst_lesser",  32'(bus.lesser),  0);
        chk("rst_greater", 32'(bus.greater), 0);
        chk("rst_equal",   32'(bus.equal),   0);
        rst = 1'b0;

        @(negedge clk); start_op(16'h1234, 16'h1234); wait_done();
        @(negedge clk); start_op(16'h8000, 16'h7FFF); wait_done();
        @(negedge clk); start_op(16'h12A4, 16'h12B0); wait_done();
        @(negedge clk); start_op(16'hC3D2, 16'hC3D2); wait_done();

        // Second start while busy must be ignored.
        @(negedge clk);
        cnt0 = done_cnt;
        start_op(16'h0001, 16'h0002);
        bus.a     = 16'hF000;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        chk("single_done", 32'(done_cnt - cnt0), 1);

        // Reset in the middle of an operation.
        @(negedge clk);
        start_op(16'h1111, 16'h1112);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy",    32'(bus.busy),    0);
        chk("midrst_done",    32'(bus.done),    0);
        chk("midrst_lesser",  32'(bus.lesser),  0);
        chk("midrst_greater", 32'(bus.greater), 0);
        chk("midrst_equal",   32'(bus.equal),   0);
        sb.delete();
        cnt0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(cnt0));
        start_op(16'h0005, 16'h0003); wait_done();

        // Back-to-back: new start in the done cycle of an equal compare.
        @(negedge clk);
        start_op(16'h4444, 16'h4444);
        wait_done();
        start_op(16'h0000, 16'h0001);
        wait_done();
        @(negedge clk);
        chk("b2b_hold_lesser", 32'(bus.lesser), 1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
